// File: rtl/game_pkg.sv
// game_pkg: shared game constants, keypad geometry and key-index mapping.
//   Holds default scan/debounce timing used by box_scanner and game_controller,
//   the row enumeration and KEY_IDX(row,col) = row*3+col.
package game_pkg;

    localparam int SCAN_DIV_DEF  = 1000;
    localparam int DB_SCANS_DEF  = 4;
    localparam int DB_CYCLES_DEF = 500000;

    localparam int ROWS = 3;
    localparam int COLS = 3;
    localparam int KEYS = ROWS * COLS;

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2
    } row_e;

    function automatic int key_idx(input int row, input int col);
        return row * COLS + col;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: 2-flop synchronizer plus counter debounce for one button.
//   clk, rst  : clock, asynchronous active-high reset
//   raw_i     : raw asynchronous button level
//   state_o   : debounced level; flips after DB_CYCLES consecutive differing samples
module debounce_bit
    import game_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic state_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;

    // The flip happens on the sample that would bring the count to DB_CYCLES,
    // so the counter itself never holds that value.
    always_comb begin
        cnt_d   = '0;
        state_d = state_q;
        if (sync_q[1] != state_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1))
                state_d = ~state_q;
            else
                cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/box_scanner.sv
// box_scanner: 3x3 keypad scanner with per-key debounce plus start/super buttons.
//   clk, rst      : clock, asynchronous active-high reset
//   row_n_o[2:0]  : active-low one-hot row drive
//   col_n_i[2:0]  : active-low column sense (async, pulled up)
//   start_raw_i   : raw start button; super_raw_i : raw super switch
//   box_o[8:0]    : debounced key-held bitmap, bit row*3+col
//   frame_o       : one-cycle pulse with the final box update of each scan
//   start_o       : one-cycle pulse per debounced start press
//   super_o       : debounced super level
module box_scanner
    import game_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEF,
    parameter int DB_SCANS  = DB_SCANS_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] row_n_o,
    input  logic [2:0] col_n_i,
    input  logic       start_raw_i,
    input  logic       super_raw_i,
    output logic [8:0] box_o,
    output logic       frame_o,
    output logic       start_o,
    output logic       super_o
);

    localparam int TW = $clog2(SCAN_DIV + 1);
    localparam int KW = $clog2(DB_SCANS + 1);

    logic [2:0]    col_s1_q, col_s2_q;
    logic [TW-1:0] tick_q, tick_d;
    row_e          row_q, row_d;
    logic [8:0]    box_q, box_d;
    logic [KW-1:0] kcnt_q [KEYS];
    logic [KW-1:0] kcnt_d [KEYS];
    logic          frame_q, frame_d;
    logic          start_st, start_prev_q;
    logic          sample;
    logic          raw_bit;

    // Columns are sampled on the last tick of a row, which leaves the two-flop
    // synchronizer time to settle after the row drive changed.
    assign sample = (tick_q == TW'(SCAN_DIV - 1));

    always_comb begin
        tick_d  = sample ? '0 : tick_q + TW'(1);
        row_d   = row_q;
        if (sample)
            row_d = (row_q == ROW0) ? ROW1 : (row_q == ROW1) ? ROW2 : ROW0;
        frame_d = sample && (row_q == ROW2);
        box_d   = box_q;
        kcnt_d  = kcnt_q;
        raw_bit = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (sample && (row_q == 2'(r))) begin
                    raw_bit = ~col_s2_q[c];
                    if (raw_bit == box_q[key_idx(r, c)])
                        kcnt_d[key_idx(r, c)] = '0;
                    else if (kcnt_q[key_idx(r, c)] == KW'(DB_SCANS - 1)) begin
                        box_d[key_idx(r, c)]  = raw_bit;
                        kcnt_d[key_idx(r, c)] = '0;
                    end else
                        kcnt_d[key_idx(r, c)] = kcnt_q[key_idx(r, c)] + KW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1_q     <= '0;
            col_s2_q     <= '0;
            tick_q       <= '0;
            row_q        <= ROW0;
            box_q        <= '0;
            kcnt_q       <= '{default: '0};
            frame_q      <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            col_s1_q     <= col_n_i;
            col_s2_q     <= col_s1_q;
            tick_q       <= tick_d;
            row_q        <= row_d;
            box_q        <= box_d;
            kcnt_q       <= kcnt_d;
            frame_q      <= frame_d;
            start_prev_q <= start_st;
        end
    end

    debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_start (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (start_raw_i),
        .state_o (start_st)
    );

    debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_super (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (super_raw_i),
        .state_o (super_o)
    );

    assign row_n_o = ~(3'b001 << row_q);
    assign box_o   = box_q;
    assign frame_o = frame_q;
    // Rising edge of the debounced level; high for the cycle after the flip.
    assign start_o = start_st & ~start_prev_q;

endmodule

// File: tb/tb_box_scanner.sv
// tb_box_scanner: randomized self-checking bench for box_scanner against a
//   scan/debounce reference model; a keypad model answers the row drive.
module tb_box_scanner;

    localparam int SD = 4;
    localparam int DS = 3;
    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] row_n;
    logic [2:0] col_n;
    logic       start_raw = 1'b0;
    logic       super_raw = 1'b0;
    logic [8:0] box;
    logic       frame, start, super_o;
    logic [8:0] keys = '0;

    int checks = 0;
    int errors = 0;

    int         n;
    logic [8:0] m_box;
    int         m_run [9];
    logic       m_frame;
    logic [2:0] m_row_n;
    logic       st_hist [$];
    logic       su_hist [$];
    logic       m_start_st, m_start_pulse, m_super_st;
    int         m_start_run, m_super_run;

    box_scanner #(.SCAN_DIV(SD), .DB_SCANS(DS), .DB_CYCLES(DC)) dut (
        .clk         (clk),
        .rst         (rst),
        .row_n_o     (row_n),
        .col_n_i     (col_n),
        .start_raw_i (start_raw),
        .super_raw_i (super_raw),
        .box_o       (box),
        .frame_o     (frame),
        .start_o     (start),
        .super_o     (super_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (keys[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    task automatic model_reset();
        n = 0;
        m_box = '0;
        foreach (m_run[i]) m_run[i] = 0;
        m_frame = 1'b0;
        m_row_n = 3'b110;
        st_hist = '{1'b0, 1'b0};
        su_hist = '{1'b0, 1'b0};
        m_start_st = 1'b0; m_start_run = 0; m_start_pulse = 1'b0;
        m_super_st = 1'b0; m_super_run = 0;
    endtask

    task automatic btn(input logic s, inout logic st, inout int run, output logic rose);
        rose = 1'b0;
        if (s !== st) begin
            run++;
            if (run == DC) begin
                st = ~st;
                run = 0;
                rose = st;
            end
        end else
            run = 0;
    endtask

    // One clock: update the model from the inputs seen at the edge, then
    // return at the falling edge where outputs are compared and inputs change.
    task automatic step();
        logic s, rose;
        @(posedge clk);
        n++;
        m_frame = 1'b0;
        if (n % SD == 0) begin
            int row;
            row = (n / SD - 1) % 3;
            for (int c = 0; c < 3; c++) begin
                int i;
                i = row * 3 + c;
                if (keys[i] !== m_box[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DS) begin
                        m_box[i] = keys[i];
                        m_run[i] = 0;
                    end
                end else
                    m_run[i] = 0;
            end
            m_frame = (row == 2);
        end
        m_row_n = ~(3'b001 << ((n / SD) % 3));
        s = st_hist.pop_front(); st_hist.push_back(start_raw);
        btn(s, m_start_st, m_start_run, rose);
        m_start_pulse = rose;
        s = su_hist.pop_front(); su_hist.push_back(super_raw);
        btn(s, m_super_st, m_super_run, rose);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        keys = 9'h1ff; start_raw = 1'b1; super_raw = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (row_n !== 3'b110) begin errors++; $display("FAIL reset_row_n: got %b expected 110", row_n); end
        checks++; if (box !== 9'h000) begin errors++; $display("FAIL reset_box: got %h expected 000", box); end
        checks++; if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected 0", frame); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", start); end
        checks++; if (super_o !== 1'b0) begin errors++; $display("FAIL reset_super: got %b expected 0", super_o); end
        keys = '0; start_raw = 1'b0; super_raw = 1'b0;
        do_reset();
        step();
        checks++; if (row_n !== m_row_n) begin errors++; $display("FAIL reset_first_row: got %b expected %b", row_n, m_row_n); end
    endtask

    task automatic test_hold_key4();
        keys = 9'h010;
        do_reset();
        repeat (40) begin
            step();
            checks++; if (box !== m_box) begin errors++; $display("FAIL key4_box n=%0d: got %h expected %h", n, box, m_box); end
            checks++; if (frame !== m_frame) begin errors++; $display("FAIL key4_frame n=%0d: got %b expected %b", n, frame, m_frame); end
            checks++; if (row_n !== m_row_n) begin errors++; $display("FAIL key4_row n=%0d: got %b expected %b", n, row_n, m_row_n); end
            if (n == 31) begin
                checks++; if (box !== 9'h000) begin errors++; $display("FAIL key4_early n=%0d: got %h expected 000", n, box); end
            end
            if (n == 32) begin
                checks++; if (box !== 9'h010) begin errors++; $display("FAIL key4_third n=%0d: got %h expected 010", n, box); end
            end
        end
    endtask

    task automatic test_toggle_key0();
        keys = 9'h001;
        do_reset();
        repeat (72) begin
            step();
            checks++; if (box[0] !== 1'b0 || box !== m_box) begin errors++; $display("FAIL toggle_box n=%0d: got %h expected %h", n, box, m_box); end
            if (n % SD == 0 && (n / SD - 1) % 3 == 0) keys[0] = ~keys[0];
        end
    endtask

    task automatic test_multi();
        keys = 9'h111;
        do_reset();
        repeat (68) begin
            step();
            checks++; if (box !== m_box) begin errors++; $display("FAIL multi_box n=%0d: got %h expected %h", n, box, m_box); end
            if (n == 36) begin
                checks++; if (box !== 9'h111) begin errors++; $display("FAIL multi_three n=%0d: got %h expected 111", n, box); end
                keys = 9'h101;
            end
            if (n == 56) begin
                checks++; if (box !== 9'h111) begin errors++; $display("FAIL multi_hold n=%0d: got %h expected 111", n, box); end
            end
        end
        checks++; if (box !== 9'h101) begin errors++; $display("FAIL multi_release n=%0d: got %h expected 101", n, box); end
    endtask

    task automatic test_random_keys();
        keys = 9'($urandom_range(0, 511));
        do_reset();
        repeat (300) begin
            step();
            checks++; if (box !== m_box) begin errors++; $display("FAIL rand_box n=%0d: got %h expected %h", n, box, m_box); end
            checks++; if (frame !== m_frame) begin errors++; $display("FAIL rand_frame n=%0d: got %b expected %b", n, frame, m_frame); end
            if (n % SD == 0 && $urandom_range(0, 2) == 0) keys = 9'($urandom_range(0, 511));
        end
    endtask

    task automatic test_start();
        int pulses, pulse_n, rise_n;
        pulses = 0; pulse_n = -1;
        keys = '0; start_raw = 1'b0; super_raw = 1'b0;
        do_reset();
        rise_n = 0;
        for (int g = 0; g < 9; g++) begin
            start_raw = (g == 8) ? 1'b0 : (g % 2 == 0);
            if (g == 6) rise_n = n;
            repeat ((g == 6) ? 30 : (g == 8) ? 15 : 3) begin
                step();
                checks++; if (start !== m_start_pulse) begin errors++; $display("FAIL start_pulse n=%0d: got %b expected %b", n, start, m_start_pulse); end
                if (start === 1'b1) begin pulses++; pulse_n = n; end
            end
            if (g < 6) start_raw = 1'b0;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL start_count: got %0d expected 1", pulses); end
        checks++; if (pulse_n != rise_n + 10) begin errors++; $display("FAIL start_latency: got %0d expected %0d", pulse_n, rise_n + 10); end
    endtask

    task automatic test_super();
        keys = '0; super_raw = 1'b0;
        do_reset();
        repeat (12) begin
            super_raw = 1'($urandom_range(0, 1));
            repeat ($urandom_range(3, 20)) begin
                step();
                checks++; if (super_o !== m_super_st) begin errors++; $display("FAIL super_level n=%0d: got %b expected %b", n, super_o, m_super_st); end
            end
        end
    endtask

    task automatic test_async_reset();
        keys = 9'h010; super_raw = 1'b1; start_raw = 1'b1;
        do_reset();
        repeat (33) begin
            step();
            checks++; if (start !== m_start_pulse || box !== m_box) begin errors++; $display("FAIL ar_pre n=%0d: got start=%b box=%h expected start=%b box=%h", n, start, box, m_start_pulse, m_box); end
        end
        checks++; if (row_n !== 3'b011 || box !== 9'h010 || super_o !== 1'b1) begin errors++; $display("FAIL ar_setup: got row=%b box=%h super=%b expected 011 010 1", row_n, box, super_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (row_n !== 3'b110) begin errors++; $display("FAIL ar_row: got %b expected 110", row_n); end
        checks++; if (box !== 9'h000 || start !== 1'b0 || super_o !== 1'b0) begin errors++; $display("FAIL ar_clear: got box=%h start=%b super=%b expected 000 0 0", box, start, super_o); end
        do_reset();
        repeat (40) begin
            step();
            checks++; if (row_n !== m_row_n || frame !== m_frame || box !== m_box) begin errors++; $display("FAIL ar_restart n=%0d: got row=%b frame=%b box=%h expected %b %b %h", n, row_n, frame, box, m_row_n, m_frame, m_box); end
            checks++; if (super_o !== m_super_st || start !== m_start_pulse) begin errors++; $display("FAIL ar_buttons n=%0d: got super=%b start=%b expected %b %b", n, super_o, start, m_super_st, m_start_pulse); end
        end
        keys = '0; super_raw = 1'b0; start_raw = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hold_key4();
        test_toggle_key0();
        test_multi();
        test_random_keys();
        test_start();
        test_super();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
